// File: rtl/tap_window_shift.sv
// Tap-window delay line: DEPTH-stage pixel shift register with registered newest/centre/oldest taps.
// Optional threshold comparators are built only when THRESH_CMP_EN is defined.
module tap_window_shift #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int CENTER = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              line_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] tap_new,
  output logic [DATA_W-1:0] tap_ctr,
  output logic [DATA_W-1:0] tap_old
`ifdef THRESH_CMP_EN
  ,
  input  logic [DATA_W-1:0] thresh,
  output logic [1:0]        brighter,
  output logic [1:0]        darker
`endif
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] tap_new_q, tap_new_d;
  logic [DATA_W-1:0] tap_ctr_q, tap_ctr_d;
  logic [DATA_W-1:0] tap_old_q, tap_old_d;
  logic              accept_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign tap_new   = tap_new_q;
  assign tap_ctr   = tap_ctr_q;
  assign tap_old   = tap_old_q;

  // Next-state: shift and reload taps on accept, drop valid on a pure consume, else hold.
  always_comb begin
    stage_d     = stage_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    tap_new_d   = tap_new_q;
    tap_ctr_d   = tap_ctr_q;
    tap_old_d   = tap_old_q;
    if (accept_s) begin
      stage_d[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      // A line restart wins over window completion so no window straddles two lines.
      if (line_start) begin
        fill_d = FILL_ONE;
      end else if (fill_q == FILL_MAX) begin
        fill_d = FILL_MAX;
      end else begin
        fill_d = fill_q + FILL_ONE;
      end
      out_valid_d = (fill_d == FILL_MAX);
      tap_new_d   = in_data;
      tap_ctr_d   = stage_q[CENTER-1];
      tap_old_d   = stage_q[DEPTH-2];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and tap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      tap_new_q   <= '0;
      tap_ctr_q   <= '0;
      tap_old_q   <= '0;
    end else begin
      stage_q     <= stage_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      tap_new_q   <= tap_new_d;
      tap_ctr_q   <= tap_ctr_d;
      tap_old_q   <= tap_old_d;
    end
  end

`ifdef THRESH_CMP_EN
  // Comparisons widen by one bit so the threshold sums cannot wrap.
  function automatic logic is_brighter(input logic [DATA_W-1:0] tap_v,
                                       input logic [DATA_W-1:0] ctr_v,
                                       input logic [DATA_W-1:0] thr_v);
    return {1'b0, tap_v} > ({1'b0, ctr_v} + {1'b0, thr_v});
  endfunction

  function automatic logic is_darker(input logic [DATA_W-1:0] tap_v,
                                     input logic [DATA_W-1:0] ctr_v,
                                     input logic [DATA_W-1:0] thr_v);
    return ({1'b0, tap_v} + {1'b0, thr_v}) < {1'b0, ctr_v};
  endfunction

  logic [1:0] brighter_q, brighter_d;
  logic [1:0] darker_q, darker_d;

  assign brighter = brighter_q;
  assign darker   = darker_q;

  // Flags follow the post-shift tap values and hold with the taps otherwise.
  always_comb begin
    brighter_d = brighter_q;
    darker_d   = darker_q;
    if (accept_s) begin
      brighter_d[0] = is_brighter(stage_q[DEPTH-2], stage_q[CENTER-1], thresh);
      brighter_d[1] = is_brighter(in_data, stage_q[CENTER-1], thresh);
      darker_d[0]   = is_darker(stage_q[DEPTH-2], stage_q[CENTER-1], thresh);
      darker_d[1]   = is_darker(in_data, stage_q[CENTER-1], thresh);
    end else begin
      brighter_d = brighter_q;
      darker_d   = darker_q;
    end
  end

  // Flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brighter_q <= 2'b00;
      darker_q   <= 2'b00;
    end else begin
      brighter_q <= brighter_d;
      darker_q   <= darker_d;
    end
  end
`endif

endmodule

// File: tb/tb_tap_window_shift.sv
// Directed self-checking bench for tap_window_shift (DATA_W=8, DEPTH=7, CENTER=3).
module tb_tap_window_shift;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       line_start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] tap_new;
  logic [7:0] tap_ctr;
  logic [7:0] tap_old;
`ifdef THRESH_CMP_EN
  logic [7:0] thresh;
  logic [1:0] brighter;
  logic [1:0] darker;
`endif

  int pass_cnt;
  int total_cnt;

  tap_window_shift #(.DATA_W(8), .DEPTH(7), .CENTER(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .line_start (line_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tap_new    (tap_new),
    .tap_ctr    (tap_ctr),
    .tap_old    (tap_old)
`ifdef THRESH_CMP_EN
    ,
    .thresh     (thresh),
    .brighter   (brighter),
    .darker     (darker)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat, clock it, and leave inputs applied; returns #1 after the edge.
  task automatic beat(input logic [7:0] d, input logic ls);
    in_valid   = 1'b1;
    in_data    = d;
    line_start = ls;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; line_start = 1'b0; out_ready = 1'b1;
`ifdef THRESH_CMP_EN
    thresh = 8'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== 25'h0) $display("FAIL reset_outputs: got %h expected 0", {out_valid, tap_new, tap_ctr, tap_old});
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 6; i++) begin
      beat(8'(i), 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL fill_valid_low beat %0d: got %b expected 0", i, out_valid);
      else pass_cnt++;
    end
    beat(8'd7, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'd7, 8'd4, 8'd1}) $display("FAIL fill_first_window: got v=%b %0d/%0d/%0d expected v=1 7/4/1", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
    beat(8'd8, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'd8, 8'd5, 8'd2}) $display("FAIL fill_beat8: got v=%b %0d/%0d/%0d expected v=1 8/5/2", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    in_data   = 8'd9;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'd8, 8'd5, 8'd2}) $display("FAIL bp_frozen cycle %0d: got v=%b %0d/%0d/%0d expected v=1 8/5/2", i, out_valid, tap_new, tap_ctr, tap_old);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    beat(8'd9, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'd9, 8'd6, 8'd3}) $display("FAIL bp_beat9: got v=%b %0d/%0d/%0d expected v=1 9/6/3", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
    beat(8'd10, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'd10, 8'd7, 8'd4}) $display("FAIL bp_beat10: got v=%b %0d/%0d/%0d expected v=1 10/7/4", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
  endtask

  task automatic test_line_restart();
    beat(8'h55, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL line_start_drop: got %b expected 0", out_valid);
    else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      beat(8'(8'h60 + i), 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL line_valid_low beat %0d: got %b expected 0", i + 1, out_valid);
      else pass_cnt++;
    end
    beat(8'h66, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'h66, 8'h63, 8'h55}) $display("FAIL line_window: got v=%b %h/%h/%h expected v=1 66/63/55", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    beat(8'h77, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== 25'h0) $display("FAIL async_reset_outputs: got %h expected 0", {out_valid, tap_new, tap_ctr, tap_old});
    else pass_cnt++;
    #2;
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      beat(8'(8'h10 + i), 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL post_reset_valid_low beat %0d: got %b expected 0", i, out_valid);
      else pass_cnt++;
    end
    beat(8'h17, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'h17, 8'h14, 8'h11}) $display("FAIL post_reset_window: got v=%b %h/%h/%h expected v=1 17/14/11", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
  endtask

  task automatic test_drain_and_refill();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b0, 8'h17, 8'h14, 8'h11}) $display("FAIL drain_consume: got v=%b %h/%h/%h expected v=0 17/14/11", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, tap_new} !== {1'b0, 8'h17}) $display("FAIL idle_hold: got v=%b %h expected v=0 17", out_valid, tap_new);
    else pass_cnt++;
    beat(8'h18, 1'b0);
    total_cnt++;
    if ({out_valid, tap_new, tap_ctr, tap_old} !== {1'b1, 8'h18, 8'h15, 8'h12}) $display("FAIL refill_saturated: got v=%b %h/%h/%h expected v=1 18/15/12", out_valid, tap_new, tap_ctr, tap_old);
    else pass_cnt++;
  endtask

`ifdef THRESH_CMP_EN
  task automatic test_thresh();
    thresh = 8'd10;
    beat(8'd100, 1'b1);
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd80, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd75, 1'b0);
    total_cnt++;
    if ({out_valid, brighter, darker} !== {1'b1, 2'b01, 2'b00}) $display("FAIL thresh_basic: got v=%b b=%b d=%b expected v=1 b=01 d=00", out_valid, brighter, darker);
    else pass_cnt++;
    beat(8'd255, 1'b1);
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd250, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    total_cnt++;
    if ({out_valid, brighter, darker} !== {1'b1, 2'b00, 2'b10}) $display("FAIL thresh_no_wrap: got v=%b b=%b d=%b expected v=1 b=00 d=10", out_valid, brighter, darker);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_fill();
    test_backpressure();
    test_line_restart();
    test_async_reset();
    test_drain_and_refill();
`ifdef THRESH_CMP_EN
    test_thresh();
`endif
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tap_window_shift.md
# tap_window_shift

Parametrised tap-window shift register for the FPGA SLAM pixel pipeline. It buffers a stream of pixels, one per accepted beat, in a DEPTH-stage delay line. It presents three registered taps per beat: newest, centre and oldest. Downstream corner/feature comparators consume these taps. Flow control is valid/ready on both sides, and the fill count restarts on line boundaries so a window never spans two lines.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- DEPTH, 7, number of delay stages; legal range is 3..64
- CENTER, 3, stage index of the centre tap (index 0 is newest); requires 0 < CENTER < DEPTH-1

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a beat
- in_data  input  DATA_W  pixel
- line_start  input  1  qualifies the current beat as the first pixel of a line; sampled only on an accepted beat
- out_valid  output  1  taps hold a full window
- out_ready  input  1  downstream consumes the taps
- tap_new  output  DATA_W  stage 0 after the shift
- tap_ctr  output  DATA_W  stage CENTER after the shift
- tap_old  output  DATA_W  stage DEPTH-1 after the shift
- thresh  input  DATA_W  comparison threshold; present only with THRESH_CMP_EN
- brighter  output  2  bit0: old vs ctr, bit1: new vs ctr; present only with THRESH_CMP_EN
- darker  output  2  same bit mapping as brighter; present only with THRESH_CMP_EN

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, with no skid buffer.
- On an accept:
  - stage[0] <= in_data; stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - Tap registers load the post-shift values: tap_new = in_data, tap_ctr = old stage[CENTER-1], tap_old = old stage[DEPTH-2].
- Fill counter `fill` is 0..DEPTH and saturates at DEPTH:
  - On an accept, fill_next = line_start ? 1 : min(fill+1, DEPTH).
  - out_valid <= (fill_next == DEPTH).
- When there is no accept and out_valid && out_ready, out_valid <= 0 and the taps hold their values.
- When there is no accept and no consume, all state holds.
- line_start does not clear stage contents. Stale data is shifted out before out_valid can reassert, which takes DEPTH accepted beats.
- line_start on a beat that also completes a window: line_start wins, fill becomes 1, and out_valid becomes 0 after the current output is consumed.
- Outputs reset to 0: out_valid, tap_new, tap_ctr, tap_old, brighter, darker.
- Internal state reset to 0: all stages and fill.

## Timing
- Latency is 1 cycle: the beat accepted at edge N appears on the taps after edge N.
- The first out_valid follows the DEPTH-th accepted beat since reset or since line_start.
- With out_ready held at 1 and in_valid held at 1, throughput is one window per cycle.
- While out_valid=1 and out_ready=0:
  - in_ready is 0.
  - Taps and flags are stable.
  - The stage contents do not shift.
- Reset mid-stream takes effect immediately and asynchronously. The first accept after reset release counts as fill=1.

## Configuration
- THRESH_CMP_EN defined:
  - The thresh, brighter and darker ports exist.
  - Flags are registered in the same cycle as the taps, computed from the post-shift values.
  - brighter[i] = tap_i > tap_ctr + thresh.
  - darker[i] = tap_i + thresh < tap_ctr.
  - Sums are computed at DATA_W+1 bits, so they never wrap.
  - Flags hold together with the taps while stalled.
- THRESH_CMP_EN undefined: the three ports and their logic are absent, and tap behaviour is identical.

## Test plan
- Fill: reset, then feed 1..7 with out_ready=1.
  - out_valid is first high after beat 7, with tap_new=7, tap_ctr=4, tap_old=1.
  - Beat 8 gives tap_new=8, tap_ctr=5, tap_old=2.
- Backpressure: with a full window, hold out_ready=0 for 3 cycles while in_valid=1.
  - in_ready=0 and taps are frozen.
  - Release out_ready: the next beat is accepted, and no data is lost or duplicated.
- Line restart: after 10 beats, send beat 0x55 with line_start=1.
  - out_valid stays 0 for the next 6 beats.
  - The 7th beat since line_start gives tap_old=0x55.
- Async reset: assert reset mid-stream between clock edges.
  - All outputs read 0 immediately.
  - 7 further beats are needed for out_valid.
- THRESH_CMP_EN: with thresh=10, window old=100, ctr=80, new=75, expect brighter=2'b01 and darker=2'b00.
- THRESH_CMP_EN overflow: with ctr=250, thresh=10, old=255, expect brighter[0]=0 (no wrap).
